// File: rtl/cart_bus_master.sv
// -----------------------------------------------------------------------------
// cart_bus_master
//
// Atari cartridge-bus initiator used by the bench/dumper fixture. It generates
// a free-running phi2 bus clock from clk and turns single host requests into
// one read or write bus cycle into the S4 ($8000), S5 ($A000) or CCTL ($D5xx)
// window of a cartridge PLD.
//
// A bus cycle always spans one complete phi2 period, from a falling edge to
// the next falling edge:
//   - at the opening fall the address, r_w and the region select are driven;
//   - during phi2 high a write drives cart_d, a read lets the cart drive it;
//   - on the last clk of phi2 high a read samples cart_d;
//   - at the closing fall the select and r_w are released and rsp_valid pulses.
// Write data stays on cart_d for one clk after the closing fall (hold time).
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   host request handshake
//   req_write             1 = write cycle, 0 = read cycle
//   req_region            00 S4, 01 S5, 10 CCTL, 11 unmapped (no select)
//   req_addr              13-bit offset within the window
//   req_wdata             write data
//   rsp_valid             one-clk completion pulse for reads and writes
//   rsp_rdata             last read data, held until the next read completes
//   rd4_sync, rd5_sync    cartridge RD4/RD5 after a 2-flop synchronizer
//   phi2                  bus clock, CLK_DIV clks low then CLK_DIV clks high
//   cart_a, cart_d        cartridge address and bidirectional data bus
//   s4_n, s5_n, cctl_n    active-low window selects
//   r_w                   1 = read, 0 = write
//   rd4, rd5              raw cartridge RD4/RD5 lines
//
// Parameters
//   CLK_DIV               clk cycles per phi2 half-period, must be >= 2
// -----------------------------------------------------------------------------
module cart_bus_master #(
  parameter int CLK_DIV = 14
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_region,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,

  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,

  output logic        rd4_sync,
  output logic        rd5_sync,

  output logic        phi2,
  output logic [12:0] cart_a,
  inout  wire  [7:0]  cart_d,
  output logic        s4_n,
  output logic        s5_n,
  output logic        cctl_n,
  output logic        r_w,
  input  logic        rd4,
  input  logic        rd5
);

  localparam int                CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    REG_S4   = 2'b00,
    REG_S5   = 2'b01,
    REG_CCTL = 2'b10,
    REG_NONE = 2'b11
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,   // accepting requests
    ST_WAIT,   // request latched, waiting for the phi2 fall that opens the cycle
    ST_LOW,    // phi2 low half of the bus cycle
    ST_HIGH    // phi2 high half of the bus cycle
  } state_t;

  // ---------------------------------------------------------------------------
  // phi2 generator: free-running, independent of bus activity
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;
  logic             phi2_rise;   // phi2 goes 0 -> 1 at this clk edge
  logic             phi2_fall;   // phi2 goes 1 -> 0 at this clk edge

  assign cnt_wrap  = (cnt == CNT_MAX);
  assign phi2_rise = cnt_wrap && !phi2;
  assign phi2_fall = cnt_wrap &&  phi2;

  // NOTE: registers are updated with non-blocking assignments so that every
  // flop samples the pre-edge values of the others, whatever the process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      phi2 <= 1'b0;
    end else if (cnt_wrap) begin
      cnt  <= '0;
      phi2 <= ~phi2;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // RD4 / RD5 synchronizers (reported only, they never gate a cycle)
  // ---------------------------------------------------------------------------
  logic rd4_meta;
  logic rd5_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd4_meta <= 1'b0;
      rd4_sync <= 1'b0;
      rd5_meta <= 1'b0;
      rd5_sync <= 1'b0;
    end else begin
      rd4_meta <= rd4;
      rd4_sync <= rd4_meta;
      rd5_meta <= rd5;
      rd5_sync <= rd5_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus-cycle FSM
  // ---------------------------------------------------------------------------
  state_t      state,      nxt_state;
  logic        wr_q,       nxt_wr;
  region_t     region_q,   nxt_region;
  logic [12:0] addr_q,     nxt_addr;
  logic [7:0]  wdata_q,    nxt_wdata;
  logic        oe_q,       nxt_oe;       // DUT drives cart_d
  logic [12:0]               nxt_cart_a;
  logic                      nxt_s4_n;
  logic                      nxt_s5_n;
  logic                      nxt_cctl_n;
  logic                      nxt_r_w;
  logic                      nxt_req_ready;
  logic                      nxt_rsp_valid;
  logic [7:0]                nxt_rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      region_q  <= REG_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      oe_q      <= 1'b0;
      cart_a    <= '0;
      s4_n      <= 1'b1;
      s5_n      <= 1'b1;
      cctl_n    <= 1'b1;
      r_w       <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= nxt_state;
      wr_q      <= nxt_wr;
      region_q  <= nxt_region;
      addr_q    <= nxt_addr;
      wdata_q   <= nxt_wdata;
      oe_q      <= nxt_oe;
      cart_a    <= nxt_cart_a;
      s4_n      <= nxt_s4_n;
      s5_n      <= nxt_s5_n;
      cctl_n    <= nxt_cctl_n;
      r_w       <= nxt_r_w;
      req_ready <= nxt_req_ready;
      rsp_valid <= nxt_rsp_valid;
      rsp_rdata <= nxt_rsp_rdata;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a value unassigned and no latch is inferred.
    nxt_state     = state;
    nxt_wr        = wr_q;
    nxt_region    = region_q;
    nxt_addr      = addr_q;
    nxt_wdata     = wdata_q;
    nxt_oe        = 1'b0;
    nxt_cart_a    = cart_a;       // address is held between cycles
    nxt_s4_n      = s4_n;
    nxt_s5_n      = s5_n;
    nxt_cctl_n    = cctl_n;
    nxt_r_w       = r_w;
    nxt_rsp_valid = 1'b0;
    nxt_rsp_rdata = rsp_rdata;

    unique case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          nxt_wr     = req_write;
          nxt_region = region_t'(req_region);
          nxt_addr   = req_addr;
          nxt_wdata  = req_wdata;
          nxt_state  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A request landing while phi2 is already low still waits for the
        // next fall, so each cycle covers one whole phi2 period.
        if (phi2_fall) begin
          nxt_cart_a = addr_q;
          nxt_r_w    = ~wr_q;
          nxt_s4_n   = (region_q != REG_S4);
          nxt_s5_n   = (region_q != REG_S5);
          nxt_cctl_n = (region_q != REG_CCTL);
          nxt_state  = ST_LOW;
        end
      end

      ST_LOW: begin
        if (phi2_rise) begin
          nxt_oe    = wr_q;
          nxt_state = ST_HIGH;
        end
      end

      ST_HIGH: begin
        // Write data stays on through the closing fall edge; the IDLE default
        // then releases it one clk later.
        nxt_oe = wr_q;
        if (phi2_fall) begin
          // cnt == CNT_MAX here: the last clk of phi2 high is the sample point.
          if (!wr_q) begin
            nxt_rsp_rdata = (region_q == REG_NONE) ? 8'hFF : cart_d;
          end
          nxt_s4_n      = 1'b1;
          nxt_s5_n      = 1'b1;
          nxt_cctl_n    = 1'b1;
          nxt_r_w       = 1'b1;
          nxt_rsp_valid = 1'b1;
          nxt_state     = ST_IDLE;
        end
      end

      default: nxt_state = ST_IDLE;
    endcase

    nxt_req_ready = (nxt_state == ST_IDLE);
  end

  assign cart_d = oe_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_cart_bus_master.sv
// -----------------------------------------------------------------------------
// tb_cart_bus_master
//
// Directed bench for cart_bus_master with CLK_DIV = 4. A small cartridge
// responder drives cart_d during phi2 high of read cycles; the data bus is
// pulled up, so an undriven bus reads as 8'hFF.
// -----------------------------------------------------------------------------
module tb_cart_bus_master;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 2 * CLK_DIV;   // clks per phi2 period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_region = 2'b00;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rd4_sync;
  logic        rd5_sync;
  logic        phi2;
  logic [12:0] cart_a;
  tri1  [7:0]  cart_d;
  logic        s4_n;
  logic        s5_n;
  logic        cctl_n;
  logic        r_w;
  logic        rd4 = 1'b0;
  logic        rd5 = 1'b0;

  // Cartridge responder
  logic        rd_active = 1'b0;
  logic [7:0]  resp_byte = 8'h00;
  assign cart_d = (rd_active && phi2 && r_w) ? resp_byte : 8'bz;

  cart_bus_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_region (req_region),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rd4_sync   (rd4_sync),
    .rd5_sync   (rd5_sync),
    .phi2       (phi2),
    .cart_a     (cart_a),
    .cart_d     (cart_d),
    .s4_n       (s4_n),
    .s5_n       (s5_n),
    .cctl_n     (cctl_n),
    .r_w        (r_w),
    .rd4        (rd4),
    .rd5        (rd5)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations, filled by bus_cycle
  int          n_s4, n_s5, n_cc, n_rw0, n_drv, n_vld, n_rdy_bad;
  logic [12:0] a_seen;
  logic        first_sel_phi2;
  logic        vld_phi2, pre_vld_phi2;
  logic [7:0]  hold_d, z_d;
  logic        timeout;

  task automatic tally(input logic wr, input logic [7:0] wd, inout logic seen_sel);
    if (!s4_n)   n_s4++;
    if (!s5_n)   n_s5++;
    if (!cctl_n) n_cc++;
    if (!r_w)    n_rw0++;
    if (rsp_valid) n_vld++;
    if (wr && cart_d === wd) n_drv++;
    if (!s4_n || !s5_n || !cctl_n) begin
      if (req_ready) n_rdy_bad++;
      if (!seen_sel) begin
        seen_sel       = 1'b1;
        first_sel_phi2 = phi2;
        a_seen         = cart_a;
      end
    end
  endtask

  // Issues one request from a negedge and observes it until one clk after the
  // write-data hold has ended. Returns at a negedge.
  task automatic bus_cycle(input logic wr, input logic [1:0] rg, input logic [12:0] ad,
                           input logic [7:0] wd, input logic [7:0] rb);
    int   k;
    logic seen_sel;
    logic prev_phi2;
    n_s4 = 0; n_s5 = 0; n_cc = 0; n_rw0 = 0; n_drv = 0; n_vld = 0; n_rdy_bad = 0;
    a_seen = '0; first_sel_phi2 = 1'b1; seen_sel = 1'b0; timeout = 1'b0;
    resp_byte = rb;
    rd_active = !wr;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    req_write  = wr;
    req_region = rg;
    req_addr   = ad;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    k = 0;
    prev_phi2 = phi2;
    while (rsp_valid !== 1'b1 && k < 200) begin
      tally(wr, wd, seen_sel);
      prev_phi2 = phi2;
      @(negedge clk);
      k++;
    end
    timeout = (rsp_valid !== 1'b1);
    tally(wr, wd, seen_sel);
    vld_phi2     = phi2;
    pre_vld_phi2 = prev_phi2;
    hold_d       = cart_d;
    @(negedge clk);
    tally(wr, wd, seen_sel);
    z_d = cart_d;
    rd_active = 1'b0;
  endtask

  int         pulses, gap, nv, bad_rdy, s4_lo, rst_vld;
  logic       prev_s4, prev_v;
  logic [7:0] got [2];

  initial begin
    // ---- 1: reset state and free-running phi2 ----
    repeat (3) @(negedge clk);
    check("rst_phi2",      {31'd0, phi2},      32'd0);
    check("rst_selects",   {29'd0, s4_n, s5_n, cctl_n}, 32'h7);
    check("rst_r_w",       {31'd0, r_w},       32'd1);
    check("rst_cart_a",    {19'd0, cart_a},    32'd0);
    check("rst_cart_d_z",  {24'd0, cart_d},    32'hFF);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (i == 0) check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      check($sformatf("phi2_free_%0d", i), {31'd0, phi2}, ((i + 1) / CLK_DIV) % 2);
    end
    check("idle_selects", {29'd0, s4_n, s5_n, cctl_n}, 32'h7);
    check("idle_cart_d_z", {24'd0, cart_d}, 32'hFF);

    // rd4/rd5 pass through two flops
    rd4 = 1'b1;
    @(negedge clk);
    check("rd4_sync_1clk", {31'd0, rd4_sync}, 32'd0);
    @(negedge clk);
    check("rd4_sync_2clk", {31'd0, rd4_sync}, 32'd1);
    check("rd5_sync_low",  {31'd0, rd5_sync}, 32'd0);
    rd4 = 1'b0;

    // ---- 2: read S5 ----
    bus_cycle(1'b0, 2'b01, 13'h0123, 8'h00, 8'hA5);
    check("t2_timeout",   {31'd0, timeout}, 32'd0);
    check("t2_s5_clks",   n_s5, PERIOD);
    check("t2_other_sel", n_s4 + n_cc, 0);
    check("t2_r_w_low",   n_rw0, 0);
    check("t2_cart_a",    {19'd0, a_seen}, 32'h0123);
    check("t2_sel_at_fall", {31'd0, first_sel_phi2}, 32'd0);
    check("t2_vld_at_fall", {30'd0, pre_vld_phi2, vld_phi2}, 32'h2);
    check("t2_vld_count", n_vld, 1);
    check("t2_rdata",     {24'd0, rsp_rdata}, 32'hA5);
    check("t2_ready_busy", n_rdy_bad, 0);

    // ---- 3: write CCTL ----
    bus_cycle(1'b1, 2'b10, 13'h00E3, 8'h5A, 8'h00);
    check("t3_timeout",   {31'd0, timeout}, 32'd0);
    check("t3_cctl_clks", n_cc, PERIOD);
    check("t3_other_sel", n_s4 + n_s5, 0);
    check("t3_r_w_low",   n_rw0, PERIOD);
    check("t3_cart_a",    {19'd0, a_seen}, 32'h00E3);
    check("t3_drive_clks", n_drv, CLK_DIV + 1);
    check("t3_hold_data", {24'd0, hold_d}, 32'h5A);
    check("t3_released",  {24'd0, z_d}, 32'hFF);
    check("t3_vld_count", n_vld, 1);
    check("t3_rdata_kept", {24'd0, rsp_rdata}, 32'hA5);

    // ---- 4: unmapped read, then a write leaves rdata alone ----
    bus_cycle(1'b0, 2'b11, 13'h0005, 8'h00, 8'h3C);
    check("t4_timeout",   {31'd0, timeout}, 32'd0);
    check("t4_no_select", n_s4 + n_s5 + n_cc, 0);
    check("t4_vld_count", n_vld, 1);
    check("t4_rdata_ff",  {24'd0, rsp_rdata}, 32'hFF);
    bus_cycle(1'b1, 2'b00, 13'h0100, 8'h33, 8'h00);
    check("t4w_s4_clks",  n_s4, PERIOD);
    check("t4w_drive_clks", n_drv, CLK_DIV + 1);
    check("t4w_rdata_kept", {24'd0, rsp_rdata}, 32'hFF);

    // ---- 5: back-to-back reads with req_valid held ----
    resp_byte  = 8'h11;
    rd_active  = 1'b1;
    req_write  = 1'b0;
    req_region = 2'b00;
    req_addr   = 13'h0040;
    req_valid  = 1'b1;
    pulses = 0; gap = 0; nv = 0; bad_rdy = 0; s4_lo = 0;
    prev_s4 = 1'b1; prev_v = 1'b0;
    got[0] = '0; got[1] = '0;
    for (int k = 0; k < 300 && nv < 2; k++) begin
      @(negedge clk);
      if (prev_v && nv == 1) req_valid = 1'b0;   // second request accepted
      if (rsp_valid) begin
        got[nv] = rsp_rdata;
        nv++;
        resp_byte = 8'h22;
      end
      if (!s4_n && prev_s4) pulses++;
      if (!s4_n) begin
        s4_lo++;
        if (req_ready) bad_rdy++;
      end else if (pulses == 1 && nv == 1) begin
        gap++;
      end
      prev_s4 = s4_n;
      prev_v  = rsp_valid;
    end
    req_valid = 1'b0;
    rd_active = 1'b0;
    check("t5_responses", nv, 2);
    check("t5_pulses",    pulses, 2);
    check("t5_s4_clks",   s4_lo, 2 * PERIOD);
    check("t5_gap_ok",    {31'd0, gap >= PERIOD}, 32'd1);
    check("t5_ready_low", bad_rdy, 0);
    check("t5_rdata_0",   {24'd0, got[0]}, 32'h11);
    check("t5_rdata_1",   {24'd0, got[1]}, 32'h22);

    // ---- 6: reset during phi2 high of a write ----
    @(negedge clk);
    for (int k = 0; k < 100 && req_ready !== 1'b1; k++) @(negedge clk);
    req_write  = 1'b1;
    req_region = 2'b10;
    req_addr   = 13'h0011;
    req_wdata  = 8'hC3;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    for (int k = 0; k < 100 && !(cctl_n === 1'b0 && phi2 === 1'b1 && cart_d === 8'hC3); k++)
      @(negedge clk);
    check("t6_in_high", {22'd0, cctl_n, phi2, cart_d}, {22'd0, 1'b0, 1'b1, 8'hC3});
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cart_d_z", {24'd0, cart_d}, 32'hFF);
    check("t6_rst_cctl_n",   {31'd0, cctl_n}, 32'd1);
    check("t6_rst_r_w",      {31'd0, r_w},    32'd1);
    rst_vld = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rst_vld++;
    end
    rst_n = 1'b1;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      if (rsp_valid || !cctl_n) rst_vld++;
    end
    check("t6_dropped", rst_vld, 0);
    bus_cycle(1'b0, 2'b00, 13'h1FFF, 8'h00, 8'h77);
    check("t6_timeout",  {31'd0, timeout}, 32'd0);
    check("t6_s4_clks",  n_s4, PERIOD);
    check("t6_cart_a",   {19'd0, a_seen}, 32'h1FFF);
    check("t6_vld_count", n_vld, 1);
    check("t6_rdata",    {24'd0, rsp_rdata}, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
